// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants for the inter-stage pipeline registers.
package pipe_reg_chain_pkg;

    // Defaults for a generic chain instance
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 2;
    localparam logic [DEF_WIDTH-1:0] DEF_RESET_VAL = '0;

    // Payload widths of the KGP_RISC inter-stage registers
    localparam int unsigned IF_ID_W  = 64;
    localparam int unsigned ID_EX_W  = 128;
    localparam int unsigned EX_MEM_W = 72;

    // Width of an occupancy counter able to hold 0..depth
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Handshake bundle between an upstream producer, the register chain and a downstream consumer.
interface pipe_reg_chain_if
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    // Environment side: produces input words, consumes output words
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    // Chain side
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_reg_chain_stage.sv
// One elastic pipeline stage: a data register plus its valid flop.
module pipe_reg_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Valid bit: cleared by flush, otherwise follows the upstream valid when loading
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= in_valid;
        end
    end

    // Data only captures real words; bubbles and flushes leave it untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= RESET_VAL;
        end else if (load && in_valid && !flush) begin
            data <= in_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register chain with bubble collapsing, flush and occupancy count.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter int unsigned      DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    pipe_reg_chain_if.slave  bus
);

    localparam int unsigned CW = cnt_w(DEPTH);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [CW-1:0]    cnt;

    // Ready ripples from the output back to the input so any bubble is filled at once
    always_comb begin
        logic r;
        r   = bus.out_ready;
        rdy = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            r      = ~vld[i] | r;
            rdy[i] = r;
        end
    end

    // Stage instances; stage 0 faces the producer
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             s_valid_in;
        logic [WIDTH-1:0] s_data_in;

        if (g == 0) begin : g_head
            assign s_valid_in = bus.in_valid & ~bus.flush;
            assign s_data_in  = bus.in_data;
        end else begin : g_body
            assign s_valid_in = vld[g-1];
            assign s_data_in  = dat[g-1];
        end

        pipe_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .load     (rdy[g]),
            .flush    (bus.flush),
            .in_valid (s_valid_in),
            .in_data  (s_data_in),
            .valid    (vld[g]),
            .data     (dat[g])
        );
    end

    // Occupancy is the popcount of the valid vector
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt = cnt + CW'(vld[i]);
        end
    end

    assign bus.in_ready  = rdy[0] & ~bus.flush;
    assign bus.out_valid = vld[DEPTH-1];
    assign bus.out_data  = dat[DEPTH-1];
    assign bus.count     = cnt;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (WIDTH=32, DEPTH=2).
module tb_pipe_reg_chain;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 2;
    localparam logic [W-1:0] RV = 32'hDEAD_BEEF;

    typedef struct {
        logic [W-1:0] d;
        int           acc;
        bit           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc_n = 0;
    int   checks = 0;
    int   failures = 0;
    int   n_emit = 0;
    bit   a;
    exp_t exp_q[$];

    pipe_reg_chain_if #(.WIDTH(W), .DEPTH(D)) bus ();

    pipe_reg_chain #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (RV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Drive one cycle of stimulus; record an accepted word as an expected output
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic f,
                       input logic orr, input bit lat, output bit acc);
        exp_t e;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.flush     = f;
        bus.out_ready = orr;
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
            e.d   = d;
            e.acc = cyc_n;
            e.lat = lat;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest outstanding word
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                n_emit++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_emit got=%h exp=none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e.d);
                    if (e.lat) chk("latency", 32'(cyc_n - e.acc), 32'(D));
                end
            end
            if (bus.flush) exp_q.delete();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_out_data", bus.out_data, RV);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 1);

        // Reset in the middle of traffic
        cyc(1, 32'h01, 0, 0, 0, a);
        cyc(1, 32'h02, 0, 0, 0, a);
        chk("pre_rst_count", 32'(bus.count), 2);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 0);
        chk("async_rst_count", 32'(bus.count), 0);
        chk("async_rst_out_data", bus.out_data, RV);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back streaming, no backpressure
        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'hA0 + 32'(i), 0, 1, 1, a);
            chk("stream_accept", 32'(a), 1);
        end
        repeat (3) cyc(0, 32'h0, 0, 1, 0, a);
        chk("stream_drained_count", 32'(bus.count), 0);
        chk("stream_drained_valid", 32'(bus.out_valid), 0);
        chk("empty_holds_last", bus.out_data, 32'hA7);

        // Backpressure: fill, stall, then one cycle of out_ready with and without input
        cyc(1, 32'h11, 0, 0, 0, a);
        cyc(1, 32'h22, 0, 0, 0, a);
        chk("bp_count", 32'(bus.count), 2);
        chk("bp_in_ready", 32'(bus.in_ready), 0);
        cyc(1, 32'h33, 0, 0, 0, a);
        chk("bp_stall_accept", 32'(a), 0);
        chk("bp_stall_out_data", bus.out_data, 32'h11);
        cyc(1, 32'h33, 0, 1, 0, a);
        chk("bp_full_accept", 32'(a), 1);
        chk("bp_full_count", 32'(bus.count), 2);
        cyc(0, 32'h0, 0, 1, 0, a);
        chk("bp_drain_count", 32'(bus.count), 1);
        cyc(0, 32'h0, 0, 1, 0, a);
        chk("bp_empty_count", 32'(bus.count), 0);

        // Bubble collapse under backpressure
        cyc(1, 32'h33, 0, 0, 0, a);
        chk("bubble_count1", 32'(bus.count), 1);
        cyc(0, 32'h0, 0, 0, 0, a);
        cyc(1, 32'h44, 0, 0, 0, a);
        chk("bubble_accept", 32'(a), 1);
        chk("bubble_count2", 32'(bus.count), 2);
        chk("bubble_head", bus.out_data, 32'h33);
        repeat (2) cyc(0, 32'h0, 0, 1, 0, a);
        chk("bubble_drained", 32'(bus.count), 0);

        // Flush of a full chain with input pending
        cyc(1, 32'h55, 0, 0, 0, a);
        cyc(1, 32'h66, 0, 0, 0, a);
        cyc(1, 32'h77, 1, 0, 0, a);
        chk("flush_accept", 32'(a), 0);
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_out_valid", 32'(bus.out_valid), 0);
        cyc(1, 32'h88, 0, 1, 1, a);
        repeat (2) cyc(0, 32'h0, 0, 1, 0, a);
        chk("post_flush_drained", 32'(bus.count), 0);

        // Flush with a partly filled chain: input refused, data registers hold
        cyc(1, 32'h99, 0, 0, 0, a);
        cyc(1, 32'hAA, 1, 0, 0, a);
        chk("flush_partial_accept", 32'(a), 0);
        chk("flush_partial_count", 32'(bus.count), 0);
        chk("flush_data_hold", bus.out_data, 32'h88);

        // Flush coinciding with an output transfer
        cyc(1, 32'hB1, 0, 0, 0, a);
        cyc(1, 32'hB2, 0, 0, 0, a);
        e0 = n_emit;
        cyc(1, 32'hB3, 1, 1, 0, a);
        chk("flush_emit_accept", 32'(a), 0);
        repeat (3) cyc(0, 32'h0, 0, 1, 0, a);
        chk("flush_emit_once", 32'(n_emit - e0), 1);
        chk("flush_emit_count", 32'(bus.count), 0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
